weight_fetch_ctrl: RTL and testbench
====================================

WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

Interface
REQ-001 Parameter NUM_LAYERS, default 4: number of layers addressable in the weight ROM.
REQ-002 Parameter WEIGHT_WIDTH, default 8: bits per weight.
REQ-003 Parameter ADDR_WIDTH, default 12: width of the intra-layer ROM address and of the burst length.
REQ-004 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1: reset, asynchronous and active-high.
REQ-006 Port start  input  1: one-cycle burst request; sampled only in IDLE.
REQ-007 Port start_layer  input  $clog2(NUM_LAYERS): layer for the burst.
REQ-008 Port start_addr  input  ADDR_WIDTH: first intra-layer address of the burst.
REQ-009 Port start_len  input  ADDR_WIDTH: number of weights in the burst.
REQ-010 Port rom_layer_sel  output  $clog2(NUM_LAYERS): drives the ROM layer select.
REQ-011 Port rom_addr  output  ADDR_WIDTH: drives the ROM address.
REQ-012 Port rom_data  input  WEIGHT_WIDTH: ROM read data, valid exactly 1 cycle after the address.
REQ-013 Port w_data  output  WEIGHT_WIDTH: weight delivered to the consumer.
REQ-014 Port w_valid  output  1 / w_ready  input  1: valid/ready handshake; a transfer occurs when both are high.
REQ-015 Port w_last  output  1: high with the final weight of a burst.
REQ-016 Port busy  output  1: high in any state except IDLE.
REQ-017 Port done  output  1: one-cycle pulse after the last transfer.

Function
REQ-018 The FSM states SHALL be IDLE, FETCH, DRAIN, DONE.
REQ-019 IDLE->FETCH on start with start_len>0; IDLE->DONE on start with start_len==0; start while busy SHALL be ignored.
REQ-020 On acceptance, the block SHALL latch the layer, the address and the remaining-issue count.
REQ-021 FETCH SHALL issue one ROM read per cycle when fifo_count + inflight - pop < 2, where pop is the w_valid&&w_ready of the same cycle.
REQ-022 Each issue SHALL advance rom_addr by 1 and decrement the remaining-issue count.
REQ-023 The address SHALL wrap modulo 2**ADDR_WIDTH.
REQ-024 The ROM read data SHALL be written into a 2-entry FIFO one cycle after issue.
REQ-025 The FIFO SHALL never overflow, under any w_ready pattern.
REQ-026 FETCH->DRAIN when the last read is issued.
REQ-027 DRAIN->DONE in the cycle the transfer with w_last occurs.
REQ-028 DONE->IDLE unconditionally after 1 cycle, with done=1 in that cycle.
REQ-029 w_valid SHALL equal FIFO not-empty; w_data SHALL be the FIFO head.
REQ-030 w_last SHALL be high only on the head entry corresponding to the final issued address.
REQ-031 With w_ready held high, the first w_valid SHALL occur 2 cycles after start (start -> issue -> FIFO write -> output), followed by 1 weight/cycle with no bubbles.
REQ-032 rom_layer_sel SHALL hold the latched layer for the whole burst; rom_addr SHALL be stable when no issue occurs.

Reset
REQ-033 Reset SHALL return the block to IDLE and clear the FIFO, inflight flag and counters.
REQ-034 Reset values: w_valid=0, w_last=0, done=0, busy=0, rom_addr=0, rom_layer_sel=0, w_data=0.
REQ-035 Reset asserted mid-burst SHALL discard all pending weights.
REQ-036 After reset deassertion, no w_valid and no done SHALL be produced until a new start.

Configuration
REQ-037 With WEIGHT_FETCH_PERF_EN defined, the block SHALL add output stall_cycles (32 bits).
REQ-038 stall_cycles SHALL count cycles with w_valid=1 and w_ready=0, saturate at all-ones, and clear on reset and on an accepted start.
REQ-039 Without WEIGHT_FETCH_PERF_EN, the port and its logic SHALL be absent, with identical behaviour otherwise.

Structure
REQ-040 The fetch-state enum typedef and the default ADDR_WIDTH constant SHALL live in the shared package tinyml_pkg.
REQ-041 The 2-entry FIFO (data plus last flag) SHALL be a separate sub-module, weight_skid_fifo.

Verification
REQ-042 Burst: layer=1, addr=5, len=4, w_ready=1 -> w_data=ROM[1][5..8] on cycles 2..5, w_last on the 4th transfer, done on cycle 6.
REQ-043 Backpressure: len=6, w_ready toggling 1,0,0,1,... -> all 6 weights delivered in order, none lost or duplicated, FIFO count never above 2.
REQ-044 Zero length: start with len=0 -> no w_valid, done pulse 1 cycle after start, busy high for exactly 1 cycle.
REQ-045 Wrap: ADDR_WIDTH=4, addr=14, len=3 -> rom_addr sequence 14, 15, 0.
REQ-046 Reset mid-burst: reset asserted after 2 of 8 transfers -> outputs reach reset values immediately; the next burst behaves normally.
REQ-047 Perf (WEIGHT_FETCH_PERF_EN defined): w_ready low for 5 cycles while w_valid=1 -> stall_cycles=5.

Source files
------------

// File: rtl/tinyml_pkg.sv
// Shared types and defaults for the tinyml weight-streaming blocks.
package tinyml_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO carrying a weight plus its end-of-burst flag.
module weight_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_last,
  output logic         not_empty,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem;
  logic [1:0]        last_q;
  logic              rd_ptr, wr_ptr;
  logic              do_push, do_pop;

  assign do_pop    = pop && (count != 2'd0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push   = push && ((count != 2'd2) || do_pop);
  assign head_data = mem[rd_ptr];
  assign head_last = last_q[rd_ptr];
  assign not_empty = (count != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      last_q <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr]    <= push_data;
        last_q[wr_ptr] <= push_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Streams a burst of weights from the layer ROM through a 2-entry FIFO to a valid/ready consumer.
// Optional WEIGHT_FETCH_PERF_EN adds a saturating stall_cycles counter.
module weight_fetch_ctrl
  import tinyml_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LW-1:0]           start_layer,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH-1:0]   start_len,
  output logic [LW-1:0]           rom_layer_sel,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [WEIGHT_WIDTH-1:0] rom_data,
  output logic [WEIGHT_WIDTH-1:0] w_data,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic                    w_last,
  output logic                    busy,
  output logic                    done
`ifdef WEIGHT_FETCH_PERF_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] remaining;
  logic                  inflight, inflight_last;
  logic [1:0]            fifo_count;
  logic                  fifo_ne, head_last;
  logic                  pop, issue;
  logic [2:0]            occ;

  assign pop   = fifo_ne && w_ready;
  // Occupancy once this cycle's pop leaves: FIFO entries plus the read still in flight.
  assign occ   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = (state == FETCH) && (remaining != '0) && (occ < 3'd2);

  assign w_valid = fifo_ne;
  assign w_last  = fifo_ne && head_last;

  // The accepting edge already presents start_addr, so the first read is issued there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      rom_addr      <= '0;
      rom_layer_sel <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rom_layer_sel <= start_layer;
          busy          <= 1'b1;
          if (start_len == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state         <= FETCH;
            rom_addr      <= start_addr;
            remaining     <= start_len - ONE;
            inflight      <= 1'b1;
            inflight_last <= (start_len == ONE);
          end
        end
        FETCH: begin
          if (remaining == '0)
            state <= DRAIN;
          else if (issue) begin
            rom_addr      <= rom_addr + ONE;
            remaining     <= remaining - ONE;
            inflight      <= 1'b1;
            inflight_last <= (remaining == ONE);
            if (remaining == ONE)
              state <= DRAIN;
          end
        end
        DRAIN: if (pop && head_last) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  weight_skid_fifo #(.W(WEIGHT_WIDTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (rom_data),
    .push_last (inflight_last),
    .pop       (pop),
    .head_data (w_data),
    .head_last (head_last),
    .not_empty (fifo_ne),
    .count     (fifo_count)
  );

`ifdef WEIGHT_FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (state == IDLE && start)
      stall_cycles <= '0;
    else if (w_valid && !w_ready && stall_cycles != '1)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: queue-based burst model checked every cycle plus literal timing pins.
module tb_weight_fetch_ctrl;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    start_layer;
  logic [AW-1:0] start_addr, start_len;
  logic [1:0]    rom_layer_sel;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data, w_data;
  logic          w_valid, w_ready, w_last, busy, done;

  logic          s4_start, s4_w_valid, s4_w_last, s4_busy, s4_done;
  logic [1:0]    s4_layer, s4_layer_sel;
  logic [3:0]    s4_addr, s4_len, s4_rom_addr;
  logic [7:0]    s4_rom_data, s4_w_data;
`ifdef WEIGHT_FETCH_PERF_EN
  logic [31:0]   stall_cycles, s4_stall;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Weight ROM contents; the DUT captures the word at the edge after it drives rom_addr.
  function automatic logic [7:0] rom_val(input int layer, input int addr);
    return 8'((layer * 37 + addr * 5 + 3) & 255);
  endfunction

  assign rom_data    = rom_val(int'(rom_layer_sel), int'(rom_addr));
  assign s4_rom_data = rom_val(int'(s4_layer_sel), int'(s4_rom_addr));

  weight_fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .start_layer(start_layer),
    .start_addr(start_addr), .start_len(start_len), .rom_layer_sel(rom_layer_sel),
    .rom_addr(rom_addr), .rom_data(rom_data), .w_data(w_data), .w_valid(w_valid),
    .w_ready(w_ready), .w_last(w_last), .busy(busy), .done(done)
`ifdef WEIGHT_FETCH_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  weight_fetch_ctrl #(.ADDR_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(s4_start), .start_layer(s4_layer),
    .start_addr(s4_addr), .start_len(s4_len), .rom_layer_sel(s4_layer_sel),
    .rom_addr(s4_rom_addr), .rom_data(s4_rom_data), .w_data(s4_w_data), .w_valid(s4_w_valid),
    .w_ready(1'b1), .w_last(s4_w_last), .busy(s4_busy), .done(s4_done)
`ifdef WEIGHT_FETCH_PERF_EN
    , .stall_cycles(s4_stall)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [7:0] d; logic last; } exp_t;
  exp_t       expq[$];
  logic       busy_exp = 1'b0, done_exp = 1'b0;
  logic [1:0] layer_exp = 2'd0;
  int         xfer_cyc[$];
  logic [7:0] xfer_dat[$];
  logic       xfer_last[$];
  int         done_cyc = -1, busy_cnt = 0, vld_cnt = 0;

  always @(negedge clk) begin
    logic nxt_busy, nxt_done;
    exp_t e;
    if (reset) begin
      chk("rst_w_valid", w_valid, 0);
      chk("rst_w_last", w_last, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_layer_sel", rom_layer_sel, 0);
      chk("rst_w_data", w_data, 0);
      expq.delete();
      busy_exp = 1'b0;
      done_exp = 1'b0;
    end else begin
      chk("done", done, done_exp);
      chk("busy", busy, busy_exp);
      if (busy_exp) chk("layer_sel", rom_layer_sel, layer_exp);
      chk("unexpected_valid", w_valid && expq.size() == 0, 0);
      if (done) done_cyc = cyc;
      if (busy) busy_cnt++;
      if (w_valid) vld_cnt++;
      nxt_done = 1'b0;
      nxt_busy = busy_exp && !done_exp;
      if (w_valid && w_ready && expq.size() != 0) begin
        e = expq.pop_front();
        chk("w_data", w_data, e.d);
        chk("w_last", w_last, e.last);
        xfer_cyc.push_back(cyc);
        xfer_dat.push_back(w_data);
        xfer_last.push_back(w_last);
        if (e.last) nxt_done = 1'b1;
      end
      if (start && !busy_exp) begin
        nxt_busy  = 1'b1;
        layer_exp = start_layer;
        if (start_len == '0) nxt_done = 1'b1;
        for (int i = 0; i < int'(start_len); i++)
          expq.push_back('{rom_val(int'(start_layer), (int'(start_addr) + i) % 4096),
                           i == int'(start_len) - 1});
      end
      busy_exp = nxt_busy;
      done_exp = nxt_done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int layer, input int addr, input int len);
    start = 1'b1; start_layer = 2'(layer); start_addr = AW'(addr); start_len = AW'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n = 0;
    while ((busy_exp || done_exp) && n < maxc) begin tick(); n++; end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, maxc);
    end
  endtask

  task automatic clear_logs();
    xfer_cyc.delete(); xfer_dat.delete(); xfer_last.delete();
    done_cyc = -1; busy_cnt = 0; vld_cnt = 0;
  endtask

  initial begin
    int sc;
    int n;
    logic [3:0] a4[6];
    logic       v4[6], dn4[6];
    logic [7:0] d4[6];
    logic       pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    reset = 1'b1; start = 1'b0; start_layer = '0; start_addr = '0; start_len = '0;
    w_ready = 1'b1; s4_start = 1'b0; s4_layer = '0; s4_addr = '0; s4_len = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();

    // Burst: layer 1, addr 5, len 4, ready held high
    clear_logs(); sc = cyc;
    do_start(1, 5, 4);
    wait_idle("burst", 20);
    chk("burst_count", xfer_cyc.size(), 4);
    if (xfer_cyc.size() == 4) begin
      chk("burst_first_cycle", xfer_cyc[0], sc + 2);
      chk("burst_last_cycle", xfer_cyc[3], sc + 5);
      chk("burst_d0", xfer_dat[0], 8'd65);
      chk("burst_d1", xfer_dat[1], 8'd70);
      chk("burst_d3", xfer_dat[3], 8'd80);
      chk("burst_last0", xfer_last[0], 0);
      chk("burst_last3", xfer_last[3], 1);
    end
    chk("burst_done_cycle", done_cyc, sc + 6);

    // Backpressure: len 6, ready pattern 1,0,0,1
    clear_logs();
    do_start(2, 4093, 6);
    n = 0;
    while ((busy_exp || done_exp) && n < 60) begin w_ready = pat[n % 4]; tick(); n++; end
    w_ready = 1'b1;
    wait_idle("backpressure", 10);
    chk("bp_count", xfer_cyc.size(), 6);

    // Zero length
    clear_logs(); sc = cyc;
    do_start(2, 7, 0);
    wait_idle("zero_len", 10);
    repeat (2) tick();
    chk("zl_done_cycle", done_cyc, sc + 1);
    chk("zl_busy_cycles", busy_cnt, 1);
    chk("zl_valid_cycles", vld_cnt, 0);

    // Start while busy is ignored
    clear_logs();
    do_start(0, 40, 3);
    do_start(3, 90, 5);
    wait_idle("ignore_start", 20);
    chk("ignore_count", xfer_cyc.size(), 3);

    // Wrap on the ADDR_WIDTH=4 instance
    s4_start = 1'b1; s4_layer = 2'd0; s4_addr = 4'd14; s4_len = 4'd3;
    tick();
    s4_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a4[i] = s4_rom_addr; v4[i] = s4_w_valid; d4[i] = s4_w_data; dn4[i] = s4_done;
    end
    tick();
    chk("wrap_addr0", a4[0], 4'd14);
    chk("wrap_addr1", a4[1], 4'd15);
    chk("wrap_addr2", a4[2], 4'd0);
    chk("wrap_v0", v4[0], 0);
    chk("wrap_d1", {v4[1], d4[1]}, {1'b1, 8'd73});
    chk("wrap_d2", {v4[2], d4[2]}, {1'b1, 8'd78});
    chk("wrap_d3", {v4[3], d4[3]}, {1'b1, 8'd3});
    chk("wrap_done", {dn4[3], dn4[4], dn4[5]}, 3'b010);

    // Reset mid-burst after two transfers
    clear_logs();
    do_start(3, 100, 8);
    n = 0;
    while (xfer_cyc.size() < 2 && n < 10) begin tick(); n++; end
    chk("mid_two_xfers", xfer_cyc.size(), 2);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", w_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", rom_addr, 0);
    chk("mid_rst_data", w_data, 0);
    tick(); tick();
    reset = 1'b0;
    clear_logs();
    repeat (6) tick();
    chk("post_rst_quiet", vld_cnt + busy_cnt, 0);
    clear_logs(); sc = cyc;
    do_start(0, 20, 3);
    wait_idle("post_rst_burst", 20);
    chk("post_rst_count", xfer_cyc.size(), 3);
    chk("post_rst_done_cycle", done_cyc, sc + 5);

`ifdef WEIGHT_FETCH_PERF_EN
    // Five stalled cycles with valid held
    clear_logs();
    w_ready = 1'b0;
    do_start(1, 0, 4);
    repeat (6) tick();
    w_ready = 1'b1;
    wait_idle("perf", 20);
    chk("stall_cycles", stall_cycles, 32'd5);
    do_start(1, 0, 0);
    chk("stall_clear", stall_cycles, 32'd0);
    wait_idle("perf_clear", 10);
`endif

    chk("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
